// File: rtl/muntjac_fpu_sticky_shifter.sv
// Pipelined bidirectional shifter for the FPU datapath.
// Right shifts jam every bit shifted out into the LSB (sticky). Left shifts
// zero-fill and raise overflow when a one is lost. The log-shifter steps are
// spread evenly over the pipeline stages, and each stage register carries its
// own valid bit under a valid/ready handshake.
module muntjac_fpu_sticky_shifter #(
  parameter int DataWidth  = 64,
  parameter int ShiftWidth = 7,
  parameter int Stages     = 2,
  parameter int TagWidth   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic                  dir_i,
  input  logic [DataWidth-1:0]  data_i,
  input  logic [ShiftWidth-1:0] shift_i,
  input  logic [TagWidth-1:0]   tag_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DataWidth-1:0]  data_o,
  output logic                  overflow_o,
  output logic [TagWidth-1:0]   tag_o
);

  localparam logic [DataWidth-1:0] all_ones = '1;

  // Per-stage pipeline registers (index Stages-1 is the output stage).
  logic [Stages-1:0]                 valid_reg;
  logic [Stages-1:0]                 sat_reg;
  logic [Stages-1:0]                 acc_reg;
  logic [Stages-1:0]                 dir_reg;
  logic [Stages-1:0][DataWidth-1:0]  data_reg;
  logic [Stages-1:0][ShiftWidth-1:0] shift_reg;
  logic [Stages-1:0][TagWidth-1:0]   tag_reg;

  // Values each stage's logic produces for its own register.
  logic [Stages-1:0]                 sat_next;
  logic [Stages-1:0]                 acc_next;
  logic [Stages-1:0]                 dir_next;
  logic [Stages-1:0][DataWidth-1:0]  data_next;
  logic [Stages-1:0][ShiftWidth-1:0] shift_next;
  logic [Stages-1:0][TagWidth-1:0]   tag_next;

  logic [Stages-1:0] advance;
  logic [Stages-1:0] load;

  for (genvar gi = 0; gi < Stages; gi++) begin : g_stage
    logic [DataWidth-1:0]  stage_data;
    logic [ShiftWidth-1:0] stage_shift;
    logic [TagWidth-1:0]   stage_tag;
    logic                  stage_sat;
    logic                  stage_acc;
    logic                  stage_dir;
    logic [DataWidth-1:0]  work_data;
    logic                  work_acc;

    if (gi == 0) begin : g_head
      // Saturation is resolved once here: the operand collapses to zero and
      // its OR becomes the accumulator, so later steps only see zeros.
      always_comb begin
        stage_sat   = (32'(shift_i) >= DataWidth);
        stage_dir   = dir_i;
        stage_shift = shift_i;
        stage_tag   = tag_i;
        stage_data  = stage_sat ? '0 : data_i;
        stage_acc   = stage_sat & (|data_i);
      end
    end else begin : g_body
      // Later stages continue from the previous stage register.
      always_comb begin
        stage_sat   = sat_reg[gi-1];
        stage_dir   = dir_reg[gi-1];
        stage_shift = shift_reg[gi-1];
        stage_tag   = tag_reg[gi-1];
        stage_data  = data_reg[gi-1];
        stage_acc   = acc_reg[gi-1];
      end
    end

    // Apply the binary steps owned by this stage, collecting lost bits.
    always_comb begin
      work_data = stage_data;
      work_acc  = stage_acc;
      for (int j = 0; j < ShiftWidth; j++) begin
        if (((j * Stages) / ShiftWidth) == gi && !stage_sat && stage_shift[j]) begin
          if (stage_dir) begin
            work_acc  = work_acc | (|(work_data & ~(all_ones >> (1 << j))));
            work_data = work_data << (1 << j);
          end else begin
            work_acc  = work_acc | (|(work_data & ~(all_ones << (1 << j))));
            work_data = work_data >> (1 << j);
          end
        end
      end
      // Right mode folds the sticky into bit 0 on the way to the output
      // stage; the accumulator then doubles as the (zero) overflow flag.
      if (gi == Stages - 1 && !stage_dir) begin
        work_data[0] = work_data[0] | work_acc;
        work_acc     = 1'b0;
      end
    end

    assign data_next[gi]  = work_data;
    assign acc_next[gi]   = work_acc;
    assign sat_next[gi]   = stage_sat;
    assign dir_next[gi]   = stage_dir;
    assign shift_next[gi] = stage_shift;
    assign tag_next[gi]   = stage_tag;
  end

  // Advance chain from the output back to the input, plus per-stage loads.
  always_comb begin
    advance = '0;
    load    = '0;
    advance[Stages-1] = valid_reg[Stages-1] & out_ready_i;
    for (int i = Stages - 2; i >= 0; i--) begin
      advance[i] = valid_reg[i] & (~valid_reg[i+1] | advance[i+1]);
    end
    load[0] = in_valid_i & (~valid_reg[0] | advance[0]);
    for (int i = 1; i < Stages; i++) begin
      load[i] = advance[i-1];
    end
  end

  assign in_ready_o = ~valid_reg[0] | advance[0];

  // Stage registers: flush beats load, load beats drain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_reg <= '0;
      sat_reg   <= '0;
      acc_reg   <= '0;
      dir_reg   <= '0;
      data_reg  <= '0;
      shift_reg <= '0;
      tag_reg   <= '0;
    end else begin
      for (int i = 0; i < Stages; i++) begin
        if (flush_i) begin
          valid_reg[i] <= 1'b0;
        end else if (load[i]) begin
          valid_reg[i] <= 1'b1;
          sat_reg[i]   <= sat_next[i];
          acc_reg[i]   <= acc_next[i];
          dir_reg[i]   <= dir_next[i];
          data_reg[i]  <= data_next[i];
          shift_reg[i] <= shift_next[i];
          tag_reg[i]   <= tag_next[i];
        end else if (advance[i]) begin
          valid_reg[i] <= 1'b0;
        end
      end
    end
  end

  assign out_valid_o = valid_reg[Stages-1];
  assign data_o      = data_reg[Stages-1];
  assign overflow_o  = acc_reg[Stages-1];
  assign tag_o       = tag_reg[Stages-1];

  // Bookkeeping fields of the output stage have no consumer.
  logic unused_tail;
  assign unused_tail = ^{shift_reg[Stages-1], sat_reg[Stages-1], dir_reg[Stages-1]};

endmodule

// File: tb/tb_muntjac_fpu_sticky_shifter.sv
// Directed bench for the sticky shifter: DataWidth=8, ShiftWidth=4, with
// Stages=2 as the main instance and Stages=1 / Stages=4 for streaming.
module tb_muntjac_fpu_sticky_shifter;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic       out_ready;
  logic       dir_in;
  logic [7:0] data_in;
  logic [3:0] shift;
  logic [3:0] tag;

  logic       in_ready2, out_valid2, ovf2;
  logic [7:0] data2;
  logic [3:0] tag2;
  logic       in_ready1, out_valid1, ovf1;
  logic [7:0] data1;
  logic [3:0] tag1;
  logic       in_ready4, out_valid4, ovf4;
  logic [7:0] data4;
  logic [3:0] tag4;

  int total = 0;
  int bad   = 0;

  logic       op_dir  [100];
  logic [7:0] op_data [100];
  logic [3:0] op_shift[100];
  logic [8:0] op_exp  [100];

  muntjac_fpu_sticky_shifter #(.DataWidth(8), .ShiftWidth(4), .Stages(2), .TagWidth(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready2),
    .dir_i(dir_in), .data_i(data_in), .shift_i(shift), .tag_i(tag), .out_valid_o(out_valid2),
    .out_ready_i(out_ready), .data_o(data2), .overflow_o(ovf2), .tag_o(tag2));

  muntjac_fpu_sticky_shifter #(.DataWidth(8), .ShiftWidth(4), .Stages(1), .TagWidth(4)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready1),
    .dir_i(dir_in), .data_i(data_in), .shift_i(shift), .tag_i(tag), .out_valid_o(out_valid1),
    .out_ready_i(out_ready), .data_o(data1), .overflow_o(ovf1), .tag_o(tag1));

  muntjac_fpu_sticky_shifter #(.DataWidth(8), .ShiftWidth(4), .Stages(4), .TagWidth(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready4),
    .dir_i(dir_in), .data_i(data_in), .shift_i(shift), .tag_i(tag), .out_valid_o(out_valid4),
    .out_ready_i(out_ready), .data_o(data4), .overflow_o(ovf4), .tag_o(tag4));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Reference behaviour, returns {overflow, data}.
  function automatic logic [8:0] model(input logic d, input logic [7:0] x, input logic [3:0] s);
    logic [7:0] r;
    logic       o;
    if (s >= 4'd8) begin
      r = d ? 8'h00 : {7'b0, |x};
      o = d ? |x : 1'b0;
    end else if (d) begin
      r = x << s;
      o = (s == 4'd0) ? 1'b0 : |(x >> (4'd8 - s));
    end else begin
      r = x >> s;
      r[0] = r[0] | (|(x & ((8'd1 << s) - 8'd1)));
      o = 1'b0;
    end
    return {o, r};
  endfunction

  // One isolated op on the Stages=2 instance: not visible after the accept
  // edge, visible after the next edge, then drained.
  task automatic do_op(input string name, input logic d, input logic [7:0] x, input logic [3:0] s,
                       input logic [3:0] t, input logic [7:0] ed, input logic eo);
    dir_in = d; data_in = x; shift = s; tag = t; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({name, "_early_valid"}, 32'(out_valid2), 32'd0);
    @(posedge clk); #1;
    check({name, "_valid"}, 32'(out_valid2), 32'd1);
    check({name, "_data"}, 32'(data2), 32'(ed));
    check({name, "_ovf"}, 32'(ovf2), 32'(eo));
    check({name, "_tag"}, 32'(tag2), 32'(t));
    $display("op %s dir=%0d data=%h s=%0d -> data_o=%h ovf=%0d", name, d, x, s, data2, ovf2);
    @(posedge clk); #1;
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    dir_in = 1'b0; data_in = 8'h00; shift = 4'd0; tag = 4'd0;

    // Reset state
    #12;
    check("rst_out_valid", 32'(out_valid2), 32'd0);
    check("rst_in_ready", 32'(in_ready2), 32'd1);
    check("rst_data", 32'(data2), 32'd0);
    check("rst_ovf", 32'(ovf2), 32'd0);
    check("rst_tag", 32'(tag2), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors
    do_op("right_sticky", 1'b0, 8'hB4, 4'd3, 4'h1, 8'h17, 1'b0);
    do_op("right_nosticky", 1'b0, 8'hB0, 4'd4, 4'h2, 8'h0B, 1'b0);
    do_op("right_s7", 1'b0, 8'h80, 4'd7, 4'h3, 8'h01, 1'b0);
    do_op("right_sat", 1'b0, 8'h80, 4'd9, 4'h4, 8'h01, 1'b0);
    do_op("right_sat_zero", 1'b0, 8'h00, 4'd15, 4'h5, 8'h00, 1'b0);
    do_op("left_sat", 1'b1, 8'h10, 4'd8, 4'h6, 8'h00, 1'b1);
    do_op("left_ovf", 1'b1, 8'h81, 4'd1, 4'h7, 8'h02, 1'b1);
    do_op("left_s4", 1'b1, 8'h0F, 4'd4, 4'h8, 8'hF0, 1'b0);
    do_op("left_s0", 1'b1, 8'h0F, 4'd0, 4'h9, 8'h0F, 1'b0);

    // Backpressure: tags 1,2,3 offered with the consumer stalled
    dir_in = 1'b0; data_in = 8'hB4; shift = 4'd3;
    out_ready = 1'b0; in_valid = 1'b1; tag = 4'd1;
    #4 check("bp_ready_1", 32'(in_ready2), 32'd1);
    @(posedge clk); #1 tag = 4'd2;
    #4 check("bp_ready_2", 32'(in_ready2), 32'd1);
    @(posedge clk); #1 tag = 4'd3;
    #4 check("bp_ready_full", 32'(in_ready2), 32'd0);
    @(posedge clk); #1;
    #4 check("bp_ready_held", 32'(in_ready2), 32'd0);
    check("bp_hold_tag", 32'(tag2), 32'd1);
    @(posedge clk); #1 out_ready = 1'b1;
    #4 check("bp_ready_release", 32'(in_ready2), 32'd1);
    check("bp_out1", {30'd0, out_valid2, 1'b0} | 32'(tag2) << 4, {30'd0, 1'b1, 1'b0} | 32'd1 << 4);
    check("bp_data1", 32'(data2), 32'h17);
    $display("bp emit tag=%0d", tag2);
    @(posedge clk); #1 in_valid = 1'b0;
    #4 check("bp_out2", {out_valid2, 27'd0, tag2}, {1'b1, 27'd0, 4'd2});
    $display("bp emit tag=%0d", tag2);
    @(posedge clk); #1;
    #4 check("bp_out3", {out_valid2, 27'd0, tag2}, {1'b1, 27'd0, 4'd3});
    $display("bp emit tag=%0d", tag2);
    @(posedge clk); #1;
    #4 check("bp_empty", 32'(out_valid2), 32'd0);
    repeat (4) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;

    // Streaming: 100 random ops, one per cycle, on all three depths
    for (int n = 0; n < 100; n++) begin
      op_dir[n]   = 1'($urandom);
      op_data[n]  = 8'($urandom);
      op_shift[n] = 4'($urandom);
      op_exp[n]   = model(op_dir[n], op_data[n], op_shift[n]);
    end
    out_ready = 1'b1;
    for (int n = 0; n < 103; n++) begin
      if (n < 100) begin
        in_valid = 1'b1; dir_in = op_dir[n]; data_in = op_data[n]; shift = op_shift[n]; tag = 4'(n);
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
        int         lat;
        int         idx;
        logic       v;
        logic       o;
        logic [7:0] d;
        logic [3:0] t;
        lat = (k == 0) ? 1 : ((k == 1) ? 2 : 4);
        v = (k == 0) ? out_valid1 : ((k == 1) ? out_valid2 : out_valid4);
        o = (k == 0) ? ovf1 : ((k == 1) ? ovf2 : ovf4);
        d = (k == 0) ? data1 : ((k == 1) ? data2 : data4);
        t = (k == 0) ? tag1 : ((k == 1) ? tag2 : tag4);
        idx = n - (lat - 1);
        if (idx >= 0 && idx < 100) begin
          check($sformatf("stream_s%0d_op%0d", lat, idx), {18'd0, v, o, d, t},
                {18'd0, 1'b1, op_exp[idx], 4'(idx)});
          if (lat == 2)
            $display("stream op%0d dir=%0d data=%h s=%0d -> data_o=%h ovf=%0d", idx, op_dir[idx],
                     op_data[idx], op_shift[idx], d, o);
        end else begin
          check($sformatf("stream_s%0d_idle_c%0d", lat, n), 32'(v), 32'd0);
        end
      end
    end

    // Flush: fill the pipeline, then flush with a new input offered
    dir_in = 1'b1; shift = 4'd1; data_in = 8'h11;
    in_valid = 1'b1; tag = 4'd5;
    @(posedge clk); #1 tag = 4'd6;
    @(posedge clk); #1;
    check("flush_pre_valid", 32'(out_valid2), 32'd1);
    flush = 1'b1; tag = 4'd7;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", 32'(out_valid2), 32'd0);
    check("flush_out_valid_s1", 32'(out_valid1), 32'd0);
    check("flush_out_valid_s4", 32'(out_valid4), 32'd0);
    check("flush_in_ready", 32'(in_ready2), 32'd1);
    $display("flush done out_valid=%0d", out_valid2);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check($sformatf("flush_no_emit_c%0d", c), 32'(out_valid2), 32'd0);
    end

    // Asynchronous reset mid-stream with a result parked at the output
    out_ready = 1'b0; in_valid = 1'b1; dir_in = 1'b1; data_in = 8'hFF; shift = 4'd0; tag = 4'hF;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1;
    check("arst_pre_data", 32'(data2), 32'hFF);
    #3 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid2), 32'd0);
    check("arst_data", 32'(data2), 32'd0);
    check("arst_ovf", 32'(ovf2), 32'd0);
    check("arst_tag", 32'(tag2), 32'd0);
    check("arst_in_ready", 32'(in_ready2), 32'd1);
    check("arst_out_valid_s4", 32'(out_valid4), 32'd0);
    $display("async reset out_valid=%0d data_o=%h", out_valid2, data2);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("arst_after_valid", 32'(out_valid2), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muntjac_fpu_sticky_shifter.md
# muntjac_fpu_sticky_shifter

Pipelined, parametrised bidirectional shifter for the FPU datapath. Right shifts jam all shifted-out bits into the LSB (sticky) for significand alignment ahead of rounding. Left shifts zero-fill and flag any lost ones (normalisation overflow detect). The block sits between exponent-difference logic and the adder/rounder, with valid/ready handshakes on both sides and a pass-through tag so callers can track operations in flight.

## Interface
- DataWidth, 64, operand/result width (≥2)
- ShiftWidth, 7, shift-amount width; amounts ≥ DataWidth are legal (saturate)
- Stages, 2, pipeline register stages, 1..ShiftWidth; latency in cycles
- TagWidth, 4, opaque sideband width (≥1)
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous kill of all in-flight operations
- in_valid_i  in  1  input operation valid
- in_ready_o  out  1  block can accept an input this cycle
- dir_i  in  1  0 = right sticky shift, 1 = left logical shift
- data_i  in  DataWidth  operand
- shift_i  in  ShiftWidth  shift amount (unsigned)
- tag_i  in  TagWidth  sideband, returned unchanged
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer accepts result
- data_o  out  DataWidth  result
- overflow_o  out  1  left mode: a 1 was shifted out; always 0 in right mode
- tag_o  out  TagWidth  tag of the result

## Operation
- Right (dir=0), shift s < DataWidth: data_o[k] = data_i[k+s] for k ≥ 1 (zero above DataWidth-1); data_o[0] = OR(data_i[s:0]).
- Right, s ≥ DataWidth: data_o = {0…0, OR(data_i)}. Sticky is never lost.
- Left (dir=1), s < DataWidth: data_o = data_i << s, zero fill; overflow_o = OR(data_i[DataWidth-1 : DataWidth-s]) (0 when s = 0).
- Left, s ≥ DataWidth: data_o = 0; overflow_o = OR(data_i).
- Decomposition: binary step j (shift by 2^j, j = 0..ShiftWidth-1) executes in stage floor(j·Stages/ShiftWidth).
  - Saturation (s ≥ DataWidth) is decided in stage 0 and carried as a flag.
  - Each step ORs its shifted-out bits into a running sticky (right) or overflow (left) accumulator.
  - In right mode, the accumulator is ORed into bit 0 at the last stage.
- Each stage register holds: valid, partial data, remaining shift bits, saturate flag, accumulator, dir, tag.
- Pipeline control: stage i advances when it is valid and (stage i+1 is empty or stage i+1 advances). The last stage advances when out_valid_o && out_ready_i.
- in_ready_o = !valid[0] || advance[0]. An input is accepted when in_valid_i && in_ready_o.
- out_valid_o = valid[Stages-1]. data_o, overflow_o and tag_o come directly from the last-stage register.
- While out_valid_o=1 and out_ready_i=0, the output stage holds its content stable.
- flush_i: all valid bits clear at the next edge. An input presented in the flush cycle is discarded. flush_i takes priority over acceptance and advancement.

## Timing
- Reset (rst_ni low, asynchronous): all valid bits 0, so out_valid_o = 0 and in_ready_o = 1. data_o = 0, overflow_o = 0, tag_o = 0.
- Latency: an input accepted at edge t is presented with out_valid_o = 1 after edge t+Stages-1. For Stages=1, the result is valid in the cycle after acceptance.
- Throughput: one operation per cycle when out_ready_i is held high.
- Capacity: at most Stages operations in flight. Results leave in strict acceptance order.
- in_ready_o depends combinationally on out_ready_i through the advance chain; in_valid_i is not in that path.
- Simultaneous accept and emit in a full pipeline is legal; the occupancy count is unchanged.
- Reset or flush mid-operation: no partial result ever appears. out_valid_o is 0 in the cycle after a flush.

## Test plan
Bench parameters: DataWidth=8, ShiftWidth=4, Stages=2, unless a scenario states otherwise.

- Right sticky: dir=0, data=0xB4, s=3 → data_o=0x17, overflow_o=0, out_valid_o after 2 edges. data=0xB0, s=4 → 0x0B (no sticky).
- Saturation: dir=0, data=0x80, s=9 → 0x01. data=0x00, s=15 → 0x00. dir=1, data=0x10, s=8 → data_o=0x00, overflow_o=1.
- Left: data=0x81, s=1 → 0x02, overflow_o=1. data=0x0F, s=4 → 0xF0, overflow_o=0. s=0 → data unchanged, overflow_o=0.
- Backpressure: hold out_ready_i=0 and offer tags 1,2,3 back to back.
  - in_ready_o falls after 2 accepts; tag 3 waits.
  - Raise out_ready_i → tags 1,2,3 emerge in order on consecutive cycles, with no loss or duplication.
- Streaming: 100 random ops with out_ready_i=1; compare against a behavioural model. Repeat with Stages=1 and Stages=4: one result per cycle at latency Stages.
- Flush/reset: fill the pipeline, assert flush_i with in_valid_i=1 → out_valid_o=0 next cycle and the flush-cycle input is never emitted. Pulse rst_ni low asynchronously mid-stream → all outputs 0 immediately.
